sm_encoder: RTL and testbench

Significance-map encoder for the IDP compression path, the write-side counterpart of the SM segment decoder. It consumes one 16-pixel segment as a pixel stream and builds a 16-bit significance map (SM), one bit per pixel, set when the pixel is nonzero. It also computes the segment's Hamming weight (HAMW). It emits SM and HAMW first, then the nonzero values (NZVL) in pixel order. This is the exact format the SM decoder consumes.

---
 rtl/sm_encoder.sv | 88 ++++++++
 tb/tb_sm_encoder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sm_encoder.sv
// sm_encoder: builds a 16-pixel significance map, Hamming weight and nonzero-value list per segment
module sm_encoder #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_start,
  output logic              busy,
  input  logic [DATA_W-1:0] px_in,
  input  logic              px_VLD,
  output logic              px_RDY,
  output logic [15:0]       SM_out,
  output logic [4:0]        HAMW_out,
  output logic              sm_VLD,
  input  logic              sm_RDY,
  output logic [DATA_W-1:0] nz_value_out,
  output logic              nz_VLD,
  input  logic              nz_RDY
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] EMIT_SM = 2'd2;
  localparam logic [1:0] EMIT_NZ = 2'd3;
  logic [1:0]        state;
  logic [15:0]       sm;
  logic [4:0]        hamw;
  logic [4:0]        cnt;
  logic [4:0]        count;
  logic [3:0]        wr_ptr;
  logic [3:0]        rd_ptr;
  logic [DATA_W-1:0] fifo [16];
  logic              px_fire;
  logic              px_nz;
  logic              nz_fire;
  assign px_nz        = |px_in;
  assign px_fire      = px_VLD & px_RDY;
  assign nz_fire      = nz_VLD & nz_RDY;
  assign busy         = state != IDLE;
  assign px_RDY       = state == COLLECT;
  assign sm_VLD       = state == EMIT_SM;
  assign nz_VLD       = (state == EMIT_NZ) && (count != 5'd0);
  assign SM_out       = sm;
  assign HAMW_out     = hamw;
  // Gated so stale storage never shows after reset or between segments
  assign nz_value_out = (count != 5'd0) ? fifo[rd_ptr] : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sm     <= '0;
      hamw   <= '0;
      cnt    <= '0;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          sm     <= '0;
          hamw   <= '0;
          cnt    <= '0;
          count  <= '0;
          wr_ptr <= '0;
          rd_ptr <= '0;
          if (op_start) state <= COLLECT;
        end
        COLLECT: if (px_fire) begin
          sm  <= {sm[14:0], px_nz};
          cnt <= cnt + 5'd1;
          if (px_nz) begin
            hamw   <= hamw + 5'd1;
            count  <= count + 5'd1;
            wr_ptr <= wr_ptr + 4'd1;
          end
          if (cnt == 5'd15) state <= EMIT_SM;
        end
        EMIT_SM: if (sm_RDY) state <= (hamw != 5'd0) ? EMIT_NZ : IDLE;
        EMIT_NZ: if (nz_fire) begin
          count  <= count - 5'd1;
          rd_ptr <= rd_ptr + 4'd1;
          if (count == 5'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk)
    if (px_fire && px_nz) fifo[wr_ptr] <= px_in;
endmodule

// File: tb/tb_sm_encoder.sv
// tb_sm_encoder: randomized self-checking bench for sm_encoder against a per-pixel reference model
module tb_sm_encoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_start = 1'b0;
  logic        px_VLD = 1'b0;
  logic        sm_RDY = 1'b0;
  logic        nz_RDY = 1'b0;
  logic [15:0] px_in = '0;
  logic        busy, px_RDY, sm_VLD, nz_VLD;
  logic [15:0] SM_out, nz_value_out;
  logic [4:0]  HAMW_out;

  sm_encoder #(.DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .op_start(op_start), .busy(busy),
    .px_in(px_in), .px_VLD(px_VLD), .px_RDY(px_RDY),
    .SM_out(SM_out), .HAMW_out(HAMW_out), .sm_VLD(sm_VLD), .sm_RDY(sm_RDY),
    .nz_value_out(nz_value_out), .nz_VLD(nz_VLD), .nz_RDY(nz_RDY)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [15:0] pix [16];
  logic [15:0] exp_sm, got_sm;
  logic [4:0]  exp_hw, got_hw;
  logic [15:0] exp_q [$];
  logic [15:0] got_q [$];
  int stall_err, nz_cycles, col_cycles;
  bit timeout, start_ok, lat_ok, idle_after_sm;

  // Reference: pixel i owns SM bit 15-i; nonzero pixels are listed in order
  task automatic model();
    exp_sm = '0;
    exp_hw = '0;
    exp_q.delete();
    for (int i = 0; i < 16; i++)
      if (pix[i] != 16'h0) begin
        exp_sm[15-i] = 1'b1;
        exp_hw = exp_hw + 5'd1;
        exp_q.push_back(pix[i]);
      end
  endtask

  // Drives one segment and records what the DUT produced; tests judge the records
  task automatic run_seg(input int gap_pct, input int sm_stall, input bit nz_toggle, input bit poke);
    int i;
    int guard;
    logic [15:0] last_v;
    bit held;
    stall_err = 0; nz_cycles = 0; col_cycles = 0; timeout = 0;
    got_q.delete();
    @(negedge clk); op_start = 1'b1;
    @(negedge clk); op_start = 1'b0;
    start_ok = busy && px_RDY;
    i = 0; guard = 0;
    while (i < 16 && guard < 500) begin
      if (!px_RDY || sm_VLD || nz_VLD) stall_err++;
      px_VLD = ($urandom_range(99) >= gap_pct);
      px_in = px_VLD ? pix[i] : 16'($urandom);
      op_start = poke && (i == 3);
      @(negedge clk); col_cycles++; guard++;
      if (px_VLD) i++;
    end
    px_VLD = 1'b0; op_start = 1'b0;
    if (guard >= 500) timeout = 1;
    lat_ok = sm_VLD && !px_RDY;
    got_sm = SM_out; got_hw = HAMW_out;
    repeat (sm_stall) begin
      px_VLD = 1'b1; px_in = 16'hBEEF;
      @(negedge clk);
      if (!sm_VLD || SM_out !== got_sm || HAMW_out !== got_hw || nz_VLD) stall_err++;
    end
    px_VLD = 1'b0;
    sm_RDY = 1'b1; @(negedge clk); sm_RDY = 1'b0;
    idle_after_sm = !busy;
    guard = 0; held = 0; last_v = '0;
    while (busy && guard < 500) begin
      if (held && (!nz_VLD || nz_value_out !== last_v)) stall_err++;
      nz_RDY = nz_toggle ? 1'($urandom_range(1)) : 1'b1;
      op_start = poke && (guard == 1);
      held = nz_VLD && !nz_RDY;
      last_v = nz_value_out;
      if (nz_VLD && nz_RDY) got_q.push_back(nz_value_out);
      @(negedge clk); nz_cycles++; guard++;
    end
    nz_RDY = 1'b0; op_start = 1'b0;
    if (guard >= 500) timeout = 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests++;
    if ({busy, px_RDY, sm_VLD, nz_VLD, SM_out, HAMW_out, nz_value_out} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got busy=%b px_RDY=%b sm_VLD=%b nz_VLD=%b SM=%h HAMW=%0d NZ=%h required all zero",
               busy, px_RDY, sm_VLD, nz_VLD, SM_out, HAMW_out, nz_value_out);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_all_zero();
    foreach (pix[i]) pix[i] = 16'h0;
    run_seg(0, 0, 0, 0);
    tests++; if (got_sm !== 16'h0000) begin fails++; $display("FAIL zero_sm got %h required 0000", got_sm); end
    tests++; if (got_hw !== 5'd0) begin fails++; $display("FAIL zero_hamw got %0d required 0", got_hw); end
    tests++; if (!idle_after_sm || nz_cycles != 0) begin fails++; $display("FAIL zero_idle got idle=%b nz_cycles=%0d required 1/0", idle_after_sm, nz_cycles); end
    tests++; if (nz_VLD !== 1'b0) begin fails++; $display("FAIL zero_nz_vld got %b required 0", nz_VLD); end
    tests++; if (!start_ok || !lat_ok || timeout) begin fails++; $display("FAIL zero_timing got start=%b lat=%b timeout=%b required 1/1/0", start_ok, lat_ok, timeout); end
  endtask

  task automatic test_sparse();
    foreach (pix[i]) pix[i] = 16'h0;
    pix[0] = 16'h1234; pix[15] = 16'h00FF;
    model();
    run_seg(0, 0, 0, 0);
    tests++; if (got_sm !== 16'h8001) begin fails++; $display("FAIL sparse_sm got %h required 8001", got_sm); end
    tests++; if (got_hw !== 5'd2) begin fails++; $display("FAIL sparse_hamw got %0d required 2", got_hw); end
    tests++; if (got_q.size() != 2) begin fails++; $display("FAIL sparse_nz_count got %0d required 2", got_q.size()); end
    else begin
      tests++; if (got_q[0] !== 16'h1234 || got_q[1] !== 16'h00FF) begin fails++; $display("FAIL sparse_nz_order got %h %h required 1234 00ff", got_q[0], got_q[1]); end
    end
    tests++; if (busy !== 1'b0 || timeout) begin fails++; $display("FAIL sparse_idle got busy=%b timeout=%b required 0/0", busy, timeout); end
  endtask

  task automatic test_full();
    foreach (pix[i]) pix[i] = 16'(i + 1);
    model();
    run_seg(0, 0, 0, 0);
    tests++; if (got_sm !== 16'hFFFF) begin fails++; $display("FAIL full_sm got %h required ffff", got_sm); end
    tests++; if (got_hw !== 5'd16) begin fails++; $display("FAIL full_hamw got %0d required 16", got_hw); end
    tests++; if (col_cycles != 16 || nz_cycles != 16) begin fails++; $display("FAIL full_throughput got collect=%0d drain=%0d required 16/16", col_cycles, nz_cycles); end
    tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL full_nz_count got %0d required %0d", got_q.size(), exp_q.size()); end
    else foreach (exp_q[k]) begin
      tests++; if (got_q[k] !== exp_q[k]) begin fails++; $display("FAIL full_nz[%0d] got %h required %h", k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] ref_q [$];
    logic [15:0] ref_sm;
    logic [4:0]  ref_hw;
    foreach (pix[i]) pix[i] = ($urandom_range(1) == 0) ? 16'h0 : 16'($urandom);
    pix[5] = 16'h8000;
    model();
    run_seg(0, 0, 0, 0);
    ref_sm = got_sm; ref_hw = got_hw; ref_q = got_q;
    run_seg(40, 5, 1, 0);
    tests++; if (got_sm !== exp_sm || got_sm !== ref_sm) begin fails++; $display("FAIL bp_sm got %h nostall %h required %h", got_sm, ref_sm, exp_sm); end
    tests++; if (got_hw !== exp_hw || got_hw !== ref_hw) begin fails++; $display("FAIL bp_hamw got %0d nostall %0d required %0d", got_hw, ref_hw, exp_hw); end
    tests++; if (got_sm[10] !== 1'b1) begin fails++; $display("FAIL bp_8000_nonzero got sm bit %b required 1", got_sm[10]); end
    tests++; if (stall_err != 0 || timeout) begin fails++; $display("FAIL bp_stability got errors=%0d timeout=%b required 0/0", stall_err, timeout); end
    tests++; if (got_q.size() != exp_q.size() || ref_q.size() != exp_q.size()) begin fails++; $display("FAIL bp_nz_count got %0d nostall %0d required %0d", got_q.size(), ref_q.size(), exp_q.size()); end
    else foreach (exp_q[k]) begin
      tests++; if (got_q[k] !== exp_q[k] || ref_q[k] !== exp_q[k]) begin fails++; $display("FAIL bp_nz[%0d] got %h nostall %h required %h", k, got_q[k], ref_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); op_start = 1'b1;
    @(negedge clk); op_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      px_VLD = 1'b1; px_in = 16'(16'h0100 + i);
      @(negedge clk);
    end
    px_VLD = 1'b0;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, px_RDY, sm_VLD, nz_VLD, SM_out, HAMW_out, nz_value_out} !== '0) begin
      fails++;
      $display("FAIL midreset_outputs got busy=%b px_RDY=%b sm_VLD=%b nz_VLD=%b SM=%h HAMW=%0d NZ=%h required all zero",
               busy, px_RDY, sm_VLD, nz_VLD, SM_out, HAMW_out, nz_value_out);
    end
    @(negedge clk); rst_n = 1'b1;
    foreach (pix[i]) pix[i] = 16'(16'h0A00 + i);
    model();
    run_seg(0, 0, 0, 0);
    tests++; if (got_sm !== 16'hFFFF || got_hw !== 5'd16) begin fails++; $display("FAIL midreset_seg got sm=%h hamw=%0d required ffff/16", got_sm, got_hw); end
    tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL midreset_nz_count got %0d required %0d", got_q.size(), exp_q.size()); end
    else foreach (exp_q[k]) begin
      tests++; if (got_q[k] !== exp_q[k]) begin fails++; $display("FAIL midreset_nz[%0d] got %h required %h", k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_ignored_start();
    foreach (pix[i]) pix[i] = (i % 3 == 0) ? 16'(16'h7000 + i) : 16'h0;
    model();
    run_seg(20, 2, 1, 1);
    tests++; if (got_sm !== exp_sm || got_hw !== exp_hw) begin fails++; $display("FAIL ignstart_sm got %h/%0d required %h/%0d", got_sm, got_hw, exp_sm, exp_hw); end
    tests++; if (got_q.size() != exp_q.size() || stall_err != 0 || timeout) begin fails++; $display("FAIL ignstart_nz got count=%0d errors=%0d timeout=%b required %0d/0/0", got_q.size(), stall_err, timeout, exp_q.size()); end
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ignstart_idle got busy=%b required 0", busy); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      foreach (pix[i]) pix[i] = ($urandom_range(1) == 0) ? 16'h0 : 16'(1 << $urandom_range(15));
      model();
      run_seg($urandom_range(50), $urandom_range(4), 1'($urandom_range(1)), 0);
      tests++; if (got_sm !== exp_sm || got_hw !== exp_hw) begin fails++; $display("FAIL rand%0d_sm got %h/%0d required %h/%0d", r, got_sm, got_hw, exp_sm, exp_hw); end
      tests++; if (stall_err != 0 || timeout) begin fails++; $display("FAIL rand%0d_stability got errors=%0d timeout=%b required 0/0", r, stall_err, timeout); end
      tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL rand%0d_nz_count got %0d required %0d", r, got_q.size(), exp_q.size()); end
      else foreach (exp_q[k]) begin
        tests++; if (got_q[k] !== exp_q[k]) begin fails++; $display("FAIL rand%0d_nz[%0d] got %h required %h", r, k, got_q[k], exp_q[k]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_sparse();
    test_full();
    test_backpressure();
    test_reset_mid();
    test_ignored_start();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
